// File: rtl/result_checker.sv
// Result checker: pops DUT results and {mask, expected} words, compares under mask, reports.
// Optional RESULT_CHECKER_FAILS_ONLY_EN: report only failing vectors.
module result_checker #(
  parameter int RTF_WIDTH = 24,
  parameter int CNT_WIDTH = 16,
  parameter int EXP_WIDTH = 2 * RTF_WIDTH,
  parameter int REP_WIDTH = 1 + CNT_WIDTH + RTF_WIDTH
) (
  input  logic                 clock_gated,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 stop_on_fail,
  input  logic                 clear,
  input  logic [RTF_WIDTH-1:0] rfifo_data,
  output logic                 rfifo_rdreq,
  input  logic                 rfifo_rdempty,
  input  logic [EXP_WIDTH-1:0] efifo_data,
  output logic                 efifo_rdreq,
  input  logic                 efifo_rdempty,
  output logic [REP_WIDTH-1:0] rep_data,
  output logic                 rep_wrreq,
  input  logic                 rep_wrfull,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] vec_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    EMIT    = 3'd3,
    HALT    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [RTF_WIDTH-1:0]   mismatch_q, mismatch_d;
  logic                   fail_q;
  logic [CNT_WIDTH-1:0]   vec_count_q, fail_count_q;
  logic                   rdreq_q, busy_q, halted_q;

  logic [RTF_WIDTH-1:0]   expected;
  logic [RTF_WIDTH-1:0]   mask;
  logic                   emit_write;
  logic                   emit_done;

  assign expected   = efifo_data[RTF_WIDTH-1:0];
  assign mask       = efifo_data[2*RTF_WIDTH-1:RTF_WIDTH];
  assign mismatch_d = (rfifo_data ^ expected) & mask;

`ifdef RESULT_CHECKER_FAILS_ONLY_EN
  // Passing vectors retire without a report, so they never wait on a full report FIFO.
  assign emit_write = (state_q == EMIT) && !rep_wrfull && fail_q;
  assign emit_done  = (state_q == EMIT) && (!rep_wrfull || !fail_q);
`else
  assign emit_write = (state_q == EMIT) && !rep_wrfull;
  assign emit_done  = emit_write;
`endif

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && !rfifo_rdempty && !efifo_rdempty && !rep_wrfull)
            state_d = READ;
        end
        READ:    state_d = CAPTURE;
        CAPTURE: state_d = EMIT;
        EMIT: begin
          if (emit_done)
            state_d = (fail_q && stop_on_fail) ? HALT : IDLE;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_gated or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mismatch_q   <= '0;
      fail_q       <= 1'b0;
      vec_count_q  <= '0;
      fail_count_q <= '0;
      rdreq_q      <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdreq_q  <= (state_d == READ);
      busy_q   <= (state_d != IDLE);
      halted_q <= (state_d == HALT);
      if (clear) begin
        mismatch_q   <= '0;
        fail_q       <= 1'b0;
        vec_count_q  <= '0;
        fail_count_q <= '0;
      end else begin
        if (state_q == CAPTURE) begin
          mismatch_q <= mismatch_d;
          fail_q     <= |mismatch_d;
        end
        // Counters stick at all-ones rather than wrapping.
        if (emit_done) begin
          if (!(&vec_count_q))
            vec_count_q <= vec_count_q + CNT_WIDTH'(1);
          if (fail_q && !(&fail_count_q))
            fail_count_q <= fail_count_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign rfifo_rdreq = rdreq_q;
  assign efifo_rdreq = rdreq_q;
  assign rep_wrreq   = emit_write;
  assign rep_data    = {fail_q, vec_count_q, mismatch_q};
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign vec_count   = vec_count_q;
  assign fail_count  = fail_count_q;

endmodule
